// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, field/affine constants and the
// GF(2^8) helpers used to build the substitution tables.
package aes_pkg;

    typedef logic [7:0] byte_t;

    // Low byte of the field polynomial x^8+x^4+x^3+x+1; x^8 is implicit.
    localparam byte_t AES_POLY      = 8'h1B;
    localparam byte_t SBOX_AFFINE_C = 8'h63;
    localparam byte_t INV_AFFINE_C  = 8'h05;

    // Multiply by x, reducing modulo the field polynomial.
    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add field multiplication.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t aa;
        byte_t bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128.
    // Zero maps to zero without a special case.
    function automatic byte_t gf_inv(input byte_t x);
        byte_t p;
        byte_t r;
        p = x;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Bit i of a right-rotation by k is b[(i+k) mod 8], so the affine
    // terms b_(i+k) are just rotated copies of the byte.
    function automatic byte_t affine(input byte_t b);
        return b
             ^ {b[3:0], b[7:4]}
             ^ {b[4:0], b[7:5]}
             ^ {b[5:0], b[7:6]}
             ^ {b[6:0], b[7]}
             ^ SBOX_AFFINE_C;
    endfunction

    function automatic byte_t inv_affine(input byte_t b);
        return {b[1:0], b[7:2]}
             ^ {b[4:0], b[7:5]}
             ^ {b[6:0], b[7]}
             ^ INV_AFFINE_C;
    endfunction

    function automatic byte_t sbox_fwd(input byte_t x);
        return affine(gf_inv(x));
    endfunction

    function automatic byte_t sbox_inv(input byte_t x);
        return gf_inv(inv_affine(x));
    endfunction

endpackage

// File: rtl/aes_sbox_if.sv
// Byte-substitution request/result bundle. The inv select exists only
// when AES_INV_SBOX_EN is defined.
interface aes_sbox_if;
    import aes_pkg::*;

    logic  in_valid;
    byte_t state;
`ifdef AES_INV_SBOX_EN
    logic  inv;
`endif
    logic  out_valid;
    byte_t Sstate;

`ifdef AES_INV_SBOX_EN
    modport master (output in_valid, output state, output inv,
                    input  out_valid, input Sstate);
    modport slave  (input  in_valid, input state, input inv,
                    output out_valid, output Sstate);
`else
    modport master (output in_valid, output state,
                    input  out_valid, input Sstate);
    modport slave  (input  in_valid, input state,
                    output out_valid, output Sstate);
`endif

endinterface

// File: rtl/aes_sbox_core.sv
// Combinational byte substitution. Tables are filled at elaboration from
// the package functions, so synthesis sees constant 256-entry ROMs.
// AES_INV_SBOX_EN adds the inverse table and the inv select.
module aes_sbox_core
    import aes_pkg::*;
(
    input  byte_t state,
`ifdef AES_INV_SBOX_EN
    input  logic  inv,
`endif
    output byte_t sub
);

    byte_t fwd_table [256];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_fwd
            assign fwd_table[gi] = sbox_fwd(byte_t'(gi));
        end
    endgenerate

`ifdef AES_INV_SBOX_EN
    byte_t inv_table [256];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_inv
            assign inv_table[gi] = sbox_inv(byte_t'(gi));
        end
    endgenerate

    assign sub = inv ? inv_table[state] : fwd_table[state];
`else
    assign sub = fwd_table[state];
`endif

endmodule

// File: rtl/aes_sbox.sv
// Registered single-byte AES S-box: result and valid appear one cycle
// after the input, straight from flops. Define AES_INV_SBOX_EN to add
// the inverse S-box selected by bus.inv.
module aes_sbox
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    aes_sbox_if.slave   bus
);

    byte_t sub_next;
    byte_t sstate_reg;
    logic  out_valid_reg;

    aes_sbox_core u_core (
        .state (bus.state),
`ifdef AES_INV_SBOX_EN
        .inv   (bus.inv),
`endif
        .sub   (sub_next)
    );

    // Capture a result for every valid input; hold data across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sstate_reg    <= 8'h00;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                sstate_reg <= sub_next;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.Sstate    = sstate_reg;

endmodule

// File: tb/tb_aes_sbox.sv
// Scoreboard bench for aes_sbox: stimulus pushes expected bytes, a monitor
// pops them whenever out_valid is seen. Reference S-box built by brute-force
// field inversion and a per-bit affine map.
module tb_aes_sbox;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] sb_q [$];
    logic [7:0] last_exp;
    int         ref_fwd [256];
    int         ref_inv [256];

    aes_sbox_if bus ();

    aes_sbox dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--)
            if (((p >> i) & 1) == 1) p = p ^ ('h11B << (i - 8));
        return p;
    endfunction

    function automatic int m_ginv(input int x);
        if (x == 0) return 0;
        for (int y = 1; y < 256; y++)
            if (m_mul(x, y) == 1) return y;
        return 0;
    endfunction

    function automatic int bit_of(input int v, input int i);
        return (v >> (i % 8)) & 1;
    endfunction

    function automatic int m_affine(input int b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++)
            r = r | ((bit_of(b, i) ^ bit_of(b, i + 4) ^ bit_of(b, i + 5) ^
                      bit_of(b, i + 6) ^ bit_of(b, i + 7) ^ bit_of('h63, i)) << i);
        return r;
    endfunction

    function automatic int m_inv_affine(input int b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++)
            r = r | ((bit_of(b, i + 2) ^ bit_of(b, i + 5) ^ bit_of(b, i + 7) ^
                      bit_of('h05, i)) << i);
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; queue the expected result.
    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic iv, input logic [7:0] exp);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.state    = d;
`ifdef AES_INV_SBOX_EN
        bus.inv      = iv;
`endif
        if (v && !r) begin
            sb_q.push_back(exp);
            last_exp = exp;
            $display("issue state=%02h inv=%0b expect=%02h", d, iv, exp);
        end
    endtask

    // Look at the outputs just after the edge that consumed the last step.
    task automatic peek(input string name, input logic v, input logic [7:0] d);
        @(posedge clk);
        #2;
        chk({name, ".valid"}, {7'd0, bus.out_valid}, {7'd0, v});
        chk({name, ".data"}, bus.Sstate, d);
    endtask

    // Monitor: pop and compare on every presented result.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %02h want none", bus.Sstate);
                end else begin
                    e = sb_q.pop_front();
                    chk("sbox_out", bus.Sstate, e);
                    $display("result Sstate=%02h expect=%02h", bus.Sstate, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] x;
        logic [7:0] dir_in  [7];
        logic [7:0] dir_out [7];
        dir_in  = '{8'h01, 8'h0A, 8'h4F, 8'h55, 8'hD0, 8'h00, 8'hFF};
        dir_out = '{8'h7C, 8'h67, 8'h84, 8'hFC, 8'h70, 8'h63, 8'h16};

        for (int i = 0; i < 256; i++) begin
            ref_fwd[i] = m_affine(m_ginv(i));
            ref_inv[i] = m_ginv(m_inv_affine(i));
        end

        bus.in_valid = 1'b0;
        bus.state    = 8'h00;
`ifdef AES_INV_SBOX_EN
        bus.inv      = 1'b0;
`endif
        last_exp = 8'h00;

        // Reset held two cycles with a valid input present.
        step(1'b1, 1'b1, 8'h01, 1'b0, 8'h00);
        peek("reset1", 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h01, 1'b0, 8'h00);
        peek("reset2", 1'b0, 8'h00);

        // Known FIPS-197 values, one cycle apart.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, dir_in[i], 1'b0, dir_out[i]);
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        end

        // Full-domain stream, back to back.
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b1, 8'(i), 1'b0, 8'(ref_fwd[i]));

        // One idle cycle: valid drops, data holds.
        step(1'b0, 1'b0, 8'h5A, 1'b0, 8'h00);
        peek("idle_hold", 1'b0, last_exp);

        // Random traffic with random gaps.
        for (int i = 0; i < 60; i++) begin
            x = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                step(1'b0, 1'b0, x, 1'b0, 8'h00);
            else
                step(1'b0, 1'b1, x, 1'b0, 8'(ref_fwd[x]));
        end

        // Reset in the middle of a valid stream.
        step(1'b0, 1'b1, 8'h33, 1'b0, 8'(ref_fwd[8'h33]));
        step(1'b1, 1'b1, 8'h44, 1'b0, 8'h00);
        peek("mid_reset", 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h53, 1'b0, 8'(ref_fwd[8'h53]));

`ifdef AES_INV_SBOX_EN
        step(1'b0, 1'b1, 8'h7C, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h63, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h16, 1'b1, 8'hFF);
        // Round trip: forward then inverse of the forward result.
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 8'(ref_fwd[i]));
            step(1'b0, 1'b1, 8'(ref_fwd[i]), 1'b1, 8'(i));
        end
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom_range(0, 255));
            step(1'b0, 1'b1, x, 1'b1, 8'(ref_inv[x]));
        end
`endif

        // Drain and confirm every issued byte came back.
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
